// File: rtl/oled_source_arbiter.sv
// Frame-synchronous arbiter sharing one OLED pixel stream among NUM_SRC screen generators.
// Optional: define OLED_ARB_BLANK_FRAME_EN to insert one blank frame between two different sources.
module oled_source_arbiter #(
  parameter int          NUM_SRC         = 4,
  parameter int          MIN_HOLD_FRAMES = 2,
  parameter logic [15:0] BLANK_COLOR     = 16'h0000
) (
  input  logic                    clock_6p25mhz,
  input  logic                    reset_n,
  input  logic                    frame_begin,
  input  logic                    sample_pixel,
  input  logic [NUM_SRC-1:0]      src_req,
  input  logic [NUM_SRC*16-1:0]   src_pixel,
  output logic [NUM_SRC-1:0]      src_grant,
  output logic [2:0]              active_src,
  output logic                    switch_pulse,
  output logic [15:0]             oled_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
`ifdef OLED_ARB_BLANK_FRAME_EN
    ST_BLANK   = 2'd2,
`endif
    ST_GRANTED = 2'd1
  } state_t;

  localparam logic [NUM_SRC-1:0] ONE_HOT_BASE = NUM_SRC'(1);

  state_t               r_state;
  logic [2:0]           r_cur;
  logic [3:0]           r_hold;
  logic [NUM_SRC-1:0]   r_grant;
  logic                 r_switch;
  logic [15:0]          r_oled;

  logic [2:0]           w_win;
  logic                 w_any;
  logic [NUM_SRC-1:0]   w_win_hot;
  logic [7:0]           w_req_ext;
  logic [127:0]         w_pix_ext;
  logic                 w_cur_req;
  logic [15:0]          w_cur_pix;
  logic [3:0]           w_hold_inc;
  logic                 w_hold_ok;
  logic                 w_unused;

  // Reserved for a future per-pixel overlay; the mux is not gated by it.
  assign w_unused = sample_pixel;

  // Lowest index wins: scan from the top so the last hit is the winner.
  always_comb begin
    w_win = 3'd0;
    w_any = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_req[i]) begin
        w_win = 3'(i);
        w_any = 1'b1;
      end
    end
  end

  // Zero-extend to the full 8-source width so a 3-bit index always fits.
  assign w_req_ext  = 8'(src_req);
  assign w_pix_ext  = 128'(src_pixel);
  assign w_cur_req  = w_req_ext[r_cur];
  assign w_cur_pix  = w_pix_ext[{r_cur, 4'b0000} +: 16];
  assign w_win_hot  = ONE_HOT_BASE << w_win;
  assign w_hold_inc = (r_hold == 4'd15) ? 4'd15 : r_hold + 4'd1;
  assign w_hold_ok  = (w_hold_inc >= 4'(MIN_HOLD_FRAMES));

  always_ff @(posedge clock_6p25mhz) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cur    <= 3'd0;
      r_hold   <= 4'd0;
      r_grant  <= '0;
      r_switch <= 1'b0;
      r_oled   <= BLANK_COLOR;
    end else begin
      r_switch <= 1'b0;
      r_oled   <= (r_state == ST_GRANTED && w_cur_req) ? w_cur_pix : BLANK_COLOR;
      if (frame_begin) begin
        case (r_state)
          ST_IDLE: begin
            if (w_any) begin
              r_state  <= ST_GRANTED;
              r_cur    <= w_win;
              r_hold   <= 4'd0;
              r_grant  <= w_win_hot;
              r_switch <= 1'b1;
            end
          end
          ST_GRANTED: begin
            if (!w_cur_req || (w_win < r_cur && w_hold_ok)) begin
              r_hold   <= 4'd0;
              r_switch <= 1'b1;
              if (!w_any) begin
                r_state <= ST_IDLE;
                r_grant <= '0;
              end else begin
`ifdef OLED_ARB_BLANK_FRAME_EN
                r_state <= ST_BLANK;
                r_grant <= '0;
`else
                r_cur   <= w_win;
                r_grant <= w_win_hot;
`endif
              end
            end else begin
              r_hold <= w_hold_inc;
            end
          end
`ifdef OLED_ARB_BLANK_FRAME_EN
          // The blank frame never counts toward hold: a fresh grant starts at 0.
          ST_BLANK: begin
            r_hold <= 4'd0;
            if (w_any) begin
              r_state  <= ST_GRANTED;
              r_cur    <= w_win;
              r_grant  <= w_win_hot;
              r_switch <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
`endif
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign src_grant    = r_grant;
  assign active_src   = r_cur;
  assign switch_pulse = r_switch;
  assign oled_data    = r_oled;

endmodule

// File: tb/tb_oled_source_arbiter.sv
// Scoreboard bench for oled_source_arbiter: each driven cycle pushes the outputs
// expected after the next edge; a negedge monitor pops and compares them.
module tb_oled_source_arbiter;

  localparam logic [3:0] M_ALL = 4'hF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_begin;
  logic        sample_pixel;
  logic [3:0]  src_req;
  logic [63:0] src_pixel;
  logic [3:0]  src_grant;
  logic [2:0]  active_src;
  logic        switch_pulse;
  logic [15:0] oled_data;

  typedef struct {
    int          cyc;
    logic [3:0]  g;
    logic [2:0]  a;
    logic        p;
    logic [15:0] o;
    logic [3:0]  m;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  oled_source_arbiter dut (
    .clock_6p25mhz (clk),
    .reset_n       (reset_n),
    .frame_begin   (frame_begin),
    .sample_pixel  (sample_pixel),
    .src_req       (src_req),
    .src_pixel     (src_pixel),
    .src_grant     (src_grant),
    .active_src    (active_src),
    .switch_pulse  (switch_pulse),
    .oled_data     (oled_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source pixels: 0=blue, 1=green, 2=red, 3=white.
  assign src_pixel = {16'hFFFF, 16'hF800, 16'h07E0, 16'h001F};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        if (sb[i].m[0]) check("src_grant",    32'(src_grant),    32'(sb[i].g));
        if (sb[i].m[1]) check("active_src",   32'(active_src),   32'(sb[i].a));
        if (sb[i].m[2]) check("switch_pulse", 32'(switch_pulse), 32'(sb[i].p));
        if (sb[i].m[3]) check("oled_data",    32'(oled_data),    32'(sb[i].o));
        sb.delete(i);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic fb, input logic [3:0] req, input logic [3:0] g,
                      input logic [2:0] a, input logic p, input logic [15:0] o,
                      input logic [3:0] m);
    exp_t e;
    frame_begin  = fb;
    src_req      = req;
    sample_pixel = ~sample_pixel;
    e.cyc = cyc + 1;
    e.g = g; e.a = a; e.p = p; e.o = o; e.m = m;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    frame_begin  = 1'b0;
    sample_pixel = 1'b0;
    src_req      = 4'b0000;

    // Reset then idle
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 16'h0000, M_ALL);
    reset_n = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 4; i++)
        step(i == 0, 4'b0000, 4'b0000, 3'd0, 1'b0, 16'h0000, M_ALL);

    // Single source 2: grant after one cycle, its pixel one cycle later
    step(1'b1, 4'b0100, 4'b0100, 3'd2, 1'b1, 16'h0000, M_ALL);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 4'b0100, 3'd2, 1'b0, 16'hF800, M_ALL);

    // Hold: source 0 requests but hold 1 < 2 keeps source 2
    for (int i = 0; i < 4; i++) step(i == 0, 4'b0101, 4'b0100, 3'd2, 1'b0, 16'hF800, M_ALL);
    // Hold 2 reached: preempt to source 0
    step(1'b1, 4'b0101, 4'b0001, 3'd0, 1'b1, 16'hF800, M_ALL);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0101, 4'b0001, 3'd0, 1'b0, 16'h001F, M_ALL);

    // No low-priority preemption across 10 frames
    for (int f = 0; f < 10; f++)
      for (int i = 0; i < 3; i++)
        step(i == 0, 4'b1111, 4'b0001, 3'd0, 1'b0, 16'h001F, M_ALL);

    // All requests drop at a boundary: IDLE, active_src held
    step(1'b1, 4'b0000, 4'b0000, 3'd0, 1'b1, 16'h0000, M_ALL);
    step(1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 16'h0000, M_ALL);

    // Mid-frame drop of source 1
    step(1'b1, 4'b0010, 4'b0010, 3'd1, 1'b1, 16'h0000, M_ALL);
    step(1'b0, 4'b0010, 4'b0010, 3'd1, 1'b0, 16'h07E0, M_ALL);
    step(1'b0, 4'b0010, 4'b0010, 3'd1, 1'b0, 16'h07E0, M_ALL);
    step(1'b0, 4'b0000, 4'b0010, 3'd1, 1'b0, 16'h0000, M_ALL);
    step(1'b0, 4'b0000, 4'b0010, 3'd1, 1'b0, 16'h0000, M_ALL);
    step(1'b1, 4'b0000, 4'b0000, 3'd1, 1'b1, 16'h0000, M_ALL);
    step(1'b0, 4'b0000, 4'b0000, 3'd1, 1'b0, 16'h0000, M_ALL);

    // Preempt 2 -> 0, direct or through one blank frame
    step(1'b1, 4'b0100, 4'b0100, 3'd2, 1'b1, 16'h0000, M_ALL);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 4'b0100, 3'd2, 1'b0, 16'hF800, M_ALL);
    for (int i = 0; i < 4; i++) step(i == 0, 4'b0101, 4'b0100, 3'd2, 1'b0, 16'hF800, M_ALL);
`ifdef OLED_ARB_BLANK_FRAME_EN
    step(1'b1, 4'b0101, 4'b0000, 3'd2, 1'b1, 16'hF800, M_ALL);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0101, 4'b0000, 3'd2, 1'b0, 16'h0000, M_ALL);
    step(1'b1, 4'b0101, 4'b0001, 3'd0, 1'b1, 16'h0000, M_ALL);
`else
    step(1'b1, 4'b0101, 4'b0001, 3'd0, 1'b1, 16'hF800, M_ALL);
`endif
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0101, 4'b0001, 3'd0, 1'b0, 16'h001F, M_ALL);

    // Reset mid-frame, then stay IDLE until the next frame_begin
    reset_n = 1'b0;
    step(1'b0, 4'b0101, 4'b0000, 3'd0, 1'b0, 16'h0000, M_ALL);
    reset_n = 1'b1;
    step(1'b0, 4'b0101, 4'b0000, 3'd0, 1'b0, 16'h0000, M_ALL);
    step(1'b0, 4'b0101, 4'b0000, 3'd0, 1'b0, 16'h0000, M_ALL);
    step(1'b1, 4'b0101, 4'b0001, 3'd0, 1'b1, 16'h0000, M_ALL);
    step(1'b0, 4'b0101, 4'b0001, 3'd0, 1'b0, 16'h001F, M_ALL);

    @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
